// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester data-memory port arbiter with bounded-burst fairness
//
// Ports:
//   clk_in, reset (async, active-low)
//   req/we/addr/wdata 0,1   : requester 0 = CPU load/store, requester 1 = loader/debug
//   gnt0/gnt1               : access issued to memory this cycle (combinational)
//   rvalid0/rvalid1, rdata  : read return, one cycle after a read grant
//   cpu_stall               : CPU requesting but not granted
//   mem_cs/we/addr/wdata    : memory command, zero when nothing is granted
//   mem_rdata               : synchronous-read memory output
module dmem_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam logic [2:0] BURST_LIM = 3'(BURST_MAX);

    owner_t     owner, owner_next;
    logic [2:0] burst_cnt, burst_cnt_next;
    logic       g0_raw, g1_raw;
    logic       at_limit;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            owner     <= IDLE;
            burst_cnt <= 3'd0;
        end else begin
            owner     <= owner_next;
            burst_cnt <= burst_cnt_next;
        end
    end

    assign at_limit = (burst_cnt == BURST_LIM);

    always_comb begin
        g0_raw         = 1'b0;
        g1_raw         = 1'b0;
        owner_next     = IDLE;
        burst_cnt_next = 3'd0;

        // The owner keeps the port while the other side is idle, or while it
        // has not yet used up its burst allowance under contention.
        case (owner)
            OWN0: begin
                if (req0 && (!req1 || !at_limit)) g0_raw = 1'b1;
                else if (req1)                    g1_raw = 1'b1;
            end
            OWN1: begin
                if (req1 && (!req0 || !at_limit)) g1_raw = 1'b1;
                else if (req0)                    g0_raw = 1'b1;
            end
            default: begin
                if (req0)      g0_raw = 1'b1;
                else if (req1) g1_raw = 1'b1;
            end
        endcase

        if (g0_raw) begin
            owner_next     = OWN0;
            burst_cnt_next = (owner == OWN0) ? (at_limit ? burst_cnt : burst_cnt + 3'd1) : 3'd1;
        end else if (g1_raw) begin
            owner_next     = OWN1;
            burst_cnt_next = (owner == OWN1) ? (at_limit ? burst_cnt : burst_cnt + 3'd1) : 3'd1;
        end
    end

    // Grants are suppressed while reset is held so memory sees no access.
    assign gnt0      = g0_raw & reset;
    assign gnt1      = g1_raw & reset;
    assign cpu_stall = req0 & ~gnt0;

    assign mem_cs    = gnt0 | gnt1;
    assign mem_we    = gnt0 ? we0    : (gnt1 ? we1    : 1'b0);
    assign mem_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
    assign mem_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
        end
    end

    assign rdata = mem_rdata;

endmodule
